// File: rtl/edge_row_cache_pkg.sv
// Shared constants and types for the edge-weight row cache.
// Defaults size the cache for graphs of up to 32 nodes with float32 weights.
package edge_row_cache_pkg;

    localparam int DEFAULT_MAX_NODES       = 32;
    localparam int DEFAULT_INDEX_WIDTH     = 6;
    localparam int DEFAULT_VALUE_WIDTH     = 32;
    localparam int DEFAULT_ADDR_WIDTH      = 32;
    localparam int DEFAULT_MAX_OUTSTANDING = 8;

    // IEEE-754 single +inf marks an absent edge in the adjacency matrix.
    localparam logic [31:0] FP_INFINITY = 32'h7F80_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN
    } fill_state_e;

endpackage

// File: rtl/edge_row_cache_if.sv
// Query handshake towards DijkstraTop plus the Avalon-MM read master towards memory.
// slave is the cache's view; master is the view of the requester/memory environment.
interface edge_row_cache_if
    import edge_row_cache_pkg::*;
#(
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
);

    logic                   ec_query;
    logic [INDEX_WIDTH-1:0] ec_from_node;
    logic [INDEX_WIDTH-1:0] ec_to_node;
    logic                   ec_ready;
    logic [VALUE_WIDTH-1:0] ec_edge_value;

    logic [ADDR_WIDTH-1:0]  avm_address;
    logic                   avm_read;
    logic                   avm_waitrequest;
    logic [VALUE_WIDTH-1:0] avm_readdata;
    logic                   avm_readdatavalid;

    modport slave (
        input  ec_query, ec_from_node, ec_to_node,
        output ec_ready, ec_edge_value,
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport master (
        output ec_query, ec_from_node, ec_to_node,
        input  ec_ready, ec_edge_value,
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );

endinterface

// File: rtl/edge_row_ram.sv
// Simple dual-port row RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module edge_row_ram #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/edge_row_cache.sv
// Edge-weight server: caches one adjacency-matrix row and answers (from, to) weight queries,
// refilling the whole row over an Avalon-MM read master on a row miss.
module edge_row_cache
    import edge_row_cache_pkg::*;
#(
    parameter int MAX_NODES       = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH     = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH     = DEFAULT_VALUE_WIDTH,
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  graph_base,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    edge_row_cache_if.slave        bus
);

    localparam int RAM_AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

    fill_state_e            state;
    logic                   row_valid;
    logic                   flush_pend;
    logic [INDEX_WIDTH-1:0] row_tag;
    logic [INDEX_WIDTH-1:0] issue_cnt;
    logic [INDEX_WIDTH-1:0] recv_cnt;

    logic                   out_vld_p1;
    logic [INDEX_WIDTH-1:0] out_from_p1;
    logic [INDEX_WIDTH-1:0] out_to_p1;
    logic [VALUE_WIDTH-1:0] rd_data_p1;

    logic                   row_hit;
    logic                   lookup;
    logic                   miss;
    logic                   issue_ok;
    logic                   ret_ok;
    logic                   more_req;
    logic [INDEX_WIDTH-1:0] outstanding;
    logic [INDEX_WIDTH-1:0] issue_next;
    logic [INDEX_WIDTH-1:0] recv_next;

    // Byte address of element [row][col]; product is double width, sum wraps at ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [ADDR_WIDTH-1:0]  base,
        input logic [INDEX_WIDTH-1:0] row,
        input logic [INDEX_WIDTH-1:0] n,
        input logic [INDEX_WIDTH-1:0] col
    );
        logic [2*INDEX_WIDTH-1:0] prod;
        prod = {{INDEX_WIDTH{1'b0}}, row} * {{INDEX_WIDTH{1'b0}}, n};
        return base + ((ADDR_WIDTH'(prod) + ADDR_WIDTH'(col)) << 2);
    endfunction

    assign row_hit     = row_valid && (row_tag == bus.ec_from_node);
    assign outstanding = issue_cnt - recv_cnt;
    assign issue_ok    = bus.avm_read && !bus.avm_waitrequest;
    // Returns with nothing in flight are leftovers from a fill aborted by reset.
    assign ret_ok      = bus.avm_readdatavalid && (outstanding != '0);
    assign issue_next  = issue_cnt + INDEX_WIDTH'(issue_ok);
    assign recv_next   = recv_cnt + INDEX_WIDTH'(ret_ok);
    // Bound ignores this cycle's return so the next accepted read can never overshoot.
    assign more_req    = (issue_next < number_of_nodes) &&
                         ((issue_next - recv_cnt) < INDEX_WIDTH'(MAX_OUTSTANDING));

    assign lookup = (state == S_IDLE) && bus.ec_query && row_hit && !flush &&
                    (bus.ec_to_node < number_of_nodes);
    assign miss   = (state == S_IDLE) && bus.ec_query && !row_hit &&
                    (number_of_nodes != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            row_valid       <= 1'b0;
            flush_pend      <= 1'b0;
            row_tag         <= '0;
            issue_cnt       <= '0;
            recv_cnt        <= '0;
            out_vld_p1      <= 1'b0;
            bus.avm_read    <= 1'b0;
            bus.avm_address <= '0;
        end else begin
            recv_cnt   <= recv_next;
            out_vld_p1 <= lookup;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        row_valid <= 1'b0;
                    end else if (miss) begin
                        row_tag         <= bus.ec_from_node;
                        row_valid       <= 1'b0;
                        issue_cnt       <= '0;
                        recv_cnt        <= '0;
                        bus.avm_read    <= 1'b1;
                        bus.avm_address <= word_addr(graph_base, bus.ec_from_node,
                                                     number_of_nodes, '0);
                        state           <= S_FILL;
                    end
                end
                S_FILL: begin
                    issue_cnt <= issue_next;
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    // Address and read are held steady while the slave stalls.
                    if (!bus.avm_read || !bus.avm_waitrequest) begin
                        bus.avm_read    <= more_req;
                        bus.avm_address <= word_addr(graph_base, row_tag,
                                                     number_of_nodes, issue_next);
                    end
                    if (issue_next == number_of_nodes) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (recv_next == number_of_nodes) begin
                        row_valid  <= !(flush_pend || flush);
                        flush_pend <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- lookup stage p1: RAM read data and the query it answers ----
    always_ff @(posedge clock) begin
        if (lookup) begin
            out_from_p1 <= bus.ec_from_node;
            out_to_p1   <= bus.ec_to_node;
        end
    end

    edge_row_ram #(
        .DEPTH  (MAX_NODES),
        .WIDTH  (VALUE_WIDTH),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ret_ok),
        .wr_addr (recv_cnt[RAM_AW-1:0]),
        .wr_data (bus.avm_readdata),
        .rd_en   (lookup),
        .rd_addr (bus.ec_to_node[RAM_AW-1:0]),
        .rd_data (rd_data_p1)
    );

    assign bus.ec_ready = bus.ec_query && out_vld_p1 && (state == S_IDLE) &&
                          (out_from_p1 == bus.ec_from_node) &&
                          (out_to_p1 == bus.ec_to_node);
    assign bus.ec_edge_value = out_vld_p1 ? rd_data_p1 : '0;

endmodule

// File: tb/tb_edge_row_cache.sv
// Directed bench for edge_row_cache with a behavioural Avalon memory and queue scoreboards.
module tb_edge_row_cache;
  import edge_row_cache_pkg::*;

  localparam int IW   = 6;
  localparam int VW   = 32;
  localparam int AW   = 32;
  localparam int MAXN = 32;
  localparam int MAXO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] graph_base = 32'h1000;
  logic [IW-1:0] number_of_nodes = 6'd8;

  edge_row_cache_if #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW)) bus ();

  edge_row_cache #(
    .MAX_NODES(MAXN), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW),
    .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .graph_base(graph_base),
    .number_of_nodes(number_of_nodes), .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_val[$];
  logic [31:0] sb_addr[$];

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;
  resp_t rq[$];
  int cyc = 0;
  int lat = 1;
  int reads = 0;
  int max_inflight = 0;
  bit wait_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] weight(input int r, input int c);
    if (r == 1 && c == 3) return FP_INFINITY;
    return 32'h4000_0000 | 32'(r << 8) | 32'(c);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int idx;
    int n;
    idx = int'((a - graph_base) >> 2);
    n   = int'(number_of_nodes);
    if (n == 0) return 32'h0;
    return weight(idx / n, idx % n);
  endfunction

  task automatic expect_fill(input int row);
    int n;
    n = int'(number_of_nodes);
    for (int i = 0; i < n; i++) sb_addr.push_back(graph_base + 32'((row * n + i) * 4));
  endtask

  // Avalon slave model: decisions made on the falling edge, seen by the DUT on the next rising edge.
  always @(negedge clock) begin
    logic [31:0] want;
    cyc++;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      bus.avm_readdata      = rq[0].data;
      bus.avm_readdatavalid = 1'b1;
      void'(rq.pop_front());
    end else begin
      bus.avm_readdatavalid = 1'b0;
    end
    bus.avm_waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (bus.avm_read === 1'b1 && bus.avm_waitrequest === 1'b0) begin
      reads++;
      want = (sb_addr.size() > 0) ? sb_addr.pop_front() : 32'hFFFF_FFFF;
      chk("avm_address", bus.avm_address, want);
      rq.push_back('{data: mem_word(bus.avm_address), due: cyc + lat});
    end
    if (rq.size() > max_inflight) max_inflight = rq.size();
  end

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (bus.ec_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic get_result(input string tag);
    bit ok;
    logic [31:0] v;
    wait_ready(300, ok);
    chk({tag, "_ready"}, 32'(ok), 32'd1);
    v = (sb_val.size() > 0) ? sb_val.pop_front() : 32'hDEAD_BEEF;
    if (ok) chk(tag, bus.ec_edge_value, v);
  endtask

  task automatic wait_inflight(input int n, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (rq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic drive_query(input int from, input int to);
    bus.ec_from_node = IW'(from);
    bus.ec_to_node   = IW'(to);
    bus.ec_query     = 1'b1;
  endtask

  task automatic idle_query();
    bus.ec_query = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int reads0;
    bit ok;
    bus.ec_query = 1'b0;
    bus.ec_from_node = '0;
    bus.ec_to_node = '0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = '0;
    bus.avm_readdatavalid = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_avm_read", 32'(bus.avm_read), 32'd0);
    chk("rst_avm_address", bus.avm_address, 32'd0);
    chk("rst_ec_ready", 32'(bus.ec_ready), 32'd0);
    chk("rst_ec_edge_value", bus.ec_edge_value, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // 1: cold query row 2, zero-wait memory
    reads0 = reads;
    expect_fill(2);
    sb_val.push_back(weight(2, 5));
    drive_query(2, 5);
    get_result("t1_cold");
    chk("t1_addr_left", 32'(sb_addr.size()), 32'd0);
    chk("t1_reads", 32'(reads - reads0), 32'd8);

    // 2: hit sweep across row 2
    reads0 = reads;
    for (int k = 0; k < 8; k++) begin
      sb_val.push_back(weight(2, k));
      bus.ec_to_node = IW'(k);
      #1;
      chk("t2_drop", 32'(bus.ec_ready), 32'd0);
      get_result("t2_hit");
      @(negedge clock);
    end
    chk("t2_no_reads", 32'(reads - reads0), 32'd0);

    // 3: random waitrequest, latency 5, then every word of the row
    idle_query();
    wait_rand = 1'b1;
    lat = 5;
    max_inflight = 0;
    expect_fill(4);
    sb_val.push_back(weight(4, 7));
    drive_query(4, 7);
    get_result("t3_miss");
    chk("t3_addr_left", 32'(sb_addr.size()), 32'd0);
    for (int k = 0; k < 8; k++) begin
      sb_val.push_back(weight(4, k));
      bus.ec_to_node = IW'(k);
      get_result("t3_word");
    end
    chk("t3_outstanding_le8", 32'(max_inflight <= MAXO), 32'd1);

    // 3b: long latency saturates the in-flight limit exactly
    wait_rand = 1'b0;
    idle_query();
    lat = 14;
    max_inflight = 0;
    expect_fill(5);
    sb_val.push_back(weight(5, 2));
    drive_query(5, 2);
    get_result("t3b_miss");
    chk("t3b_max_inflight", 32'(max_inflight), 32'(MAXO));

    // 4: from_node switched mid-fill
    idle_query();
    lat = 3;
    reads0 = reads;
    expect_fill(2);
    expect_fill(6);
    sb_val.push_back(weight(6, 1));
    drive_query(2, 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (reads - reads0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_midfill", 32'(ok), 32'd1);
    bus.ec_from_node = IW'(6);
    get_result("t4_row6");
    chk("t4_addr_left", 32'(sb_addr.size()), 32'd0);

    // 5: reset during fill with reads in flight
    idle_query();
    lat = 6;
    expect_fill(3);
    drive_query(3, 4);
    wait_inflight(3, 50, "t5_inflight");
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_avm_read", 32'(bus.avm_read), 32'd0);
    chk("t5_rst_avm_address", bus.avm_address, 32'd0);
    chk("t5_rst_ec_ready", 32'(bus.ec_ready), 32'd0);
    chk("t5_rst_value", bus.ec_edge_value, 32'd0);
    sb_addr.delete();
    bus.ec_query = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_stale_drained", 32'(ok), 32'd1);
    @(negedge clock);
    expect_fill(3);
    sb_val.push_back(weight(3, 4));
    drive_query(3, 4);
    get_result("t5_refetch");
    chk("t5_addr_left", 32'(sb_addr.size()), 32'd0);

    // 6: absent edge, flush, refetch
    idle_query();
    lat = 2;
    number_of_nodes = 6'd4;
    graph_base = 32'h2000;
    expect_fill(1);
    sb_val.push_back(FP_INFINITY);
    drive_query(1, 3);
    get_result("t6_absent");
    flush = 1'b1;
    expect_fill(1);
    sb_val.push_back(FP_INFINITY);
    @(negedge clock);
    flush = 1'b0;
    chk("t6_flush_drop", 32'(bus.ec_ready), 32'd0);
    get_result("t6_refetch");
    chk("t6_addr_left", 32'(sb_addr.size()), 32'd0);

    // Boundaries: column out of range, query low, zero-node graph
    reads0 = reads;
    bus.ec_to_node = IW'(4);
    repeat (10) @(negedge clock);
    chk("bnd_to_ge_n", 32'(bus.ec_ready), 32'd0);
    bus.ec_to_node = IW'(2);
    bus.ec_query = 1'b0;
    repeat (2) @(negedge clock);
    chk("bnd_query_low", 32'(bus.ec_ready), 32'd0);
    sb_val.push_back(weight(1, 2));
    bus.ec_query = 1'b1;
    get_result("bnd_hit_again");
    number_of_nodes = 6'd0;
    drive_query(2, 0);
    repeat (10) @(negedge clock);
    chk("bnd_n0_ready", 32'(bus.ec_ready), 32'd0);
    chk("bnd_no_reads", 32'(reads - reads0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
